hilo_muldiv_unit: RTL

- Sequential HI/LO execution unit for the MIPS datapath; successor to the combinational ALU control decode.
- Accepts the 5-bit ALU control codes for the multiply/HI-LO class, plus new DIV/DIVU codes.
- Runs multi-cycle multiply, multiply-accumulate and iterative divide, and owns the architectural HI/LO registers.
- Sits beside the ALU in EX; the pipeline stalls on Busy.

---
 rtl/hilo_muldiv_unit.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : Sequential HI/LO unit for the EX stage. It runs multi-cycle
//            MULT/MULTU/MADD/MSUB and, optionally, iterative restoring
//            DIV/DIVU. It also owns the architectural HI/LO registers and
//            serves MFHI/MFLO/MTHI/MTLO in a single cycle.
// Options  : HILO_DIV_EN - when defined, the divider datapath and DIV state
//            are built. When undefined, DIV/DIVU decode as illegal ops and
//            DivZero is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [4:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cancel,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             DivZero,
   output logic             IllegalOp
);

   localparam logic [4:0] OP_MULT  = 5'b00011;
   localparam logic [4:0] OP_MULTU = 5'b00100;
   localparam logic [4:0] OP_MADD  = 5'b10100;
   localparam logic [4:0] OP_MSUB  = 5'b10101;
   localparam logic [4:0] OP_MFHI  = 5'b10111;
   localparam logic [4:0] OP_MFLO  = 5'b11000;
   localparam logic [4:0] OP_MTHI  = 5'b11001;
   localparam logic [4:0] OP_MTLO  = 5'b11010;

   localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4:0]         op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic               busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
   logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;

   // Multiply datapath: from IDLE the live operands are used so that a
   // single-cycle multiply can commit straight away.
   logic [4:0]         mul_op;
   logic [WIDTH-1:0]   mul_a, mul_b;
   logic [2*WIDTH-1:0] prod_s, prod_u, mul_res;

   assign mul_op = (state_q == ST_IDLE) ? Op : op_q;
   assign mul_a  = (state_q == ST_IDLE) ? A  : opa_q;
   assign mul_b  = (state_q == ST_IDLE) ? B  : opb_q;
   // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product
   assign prod_s = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} * {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
   assign prod_u = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};

   // Select the HI:LO value to commit for the latched multiply-class op
   always_comb begin
      mul_res = prod_s;
      case (mul_op)
         OP_MULTU: mul_res = prod_u;
         OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
         OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
         default:  mul_res = prod_s;
      endcase
   end

`ifdef HILO_DIV_EN
   localparam logic [4:0] OP_DIV  = 5'b11011;
   localparam logic [4:0] OP_DIVU = 5'b11100;
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH);

   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, divzero_q, divzero_d;
   logic             a_sgn, b_sgn, div_ge;
   logic [WIDTH-1:0] a_mag, b_mag, step_quo, step_rem, fin_quo, fin_rem;
   logic [WIDTH:0]   div_shift, div_trial;

   // Operands enter the divider as magnitudes; signs are applied at the end
   assign a_sgn     = (Op == OP_DIV) & A[WIDTH-1];
   assign b_sgn     = (Op == OP_DIV) & B[WIDTH-1];
   assign a_mag     = a_sgn ? -A : A;
   assign b_mag     = b_sgn ? -B : B;
   // One restoring step: shift in the next dividend bit, try to subtract
   assign div_shift = {rem_q, quo_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opb_q};
   assign div_ge    = ~div_trial[WIDTH];
   assign step_rem  = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign step_quo  = {quo_q[WIDTH-2:0], div_ge};
   // A zero divisor returns all ones and the original dividend (opa_q keeps |A|)
   assign fin_quo   = dz_q ? '1 : (qneg_q ? -step_quo : step_quo);
   assign fin_rem   = dz_q ? (rneg_q ? -opa_q : opa_q)
                           : (rneg_q ? -step_rem : step_rem);
`endif

   // Next-state and next-output computation for the whole unit
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      result_d  = result_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
`ifdef HILO_DIV_EN
      quo_d     = quo_q;
      rem_d     = rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      dz_d      = dz_q;
      divzero_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               case (Op)
                  OP_MFHI: begin result_d = hi_q; done_d = 1'b1; end
                  OP_MFLO: begin result_d = lo_q; done_d = 1'b1; end
                  OP_MTHI: begin hi_d = A; done_d = 1'b1; end
                  OP_MTLO: begin lo_d = A; done_d = 1'b1; end
                  OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                     op_d  = Op;
                     opa_d = A;
                     opb_d = B;
                     if (MUL_CYCLES == 1) begin
                        hi_d   = mul_res[2*WIDTH-1:WIDTH];
                        lo_d   = mul_res[WIDTH-1:0];
                        done_d = 1'b1;
                     end else begin
                        state_d = ST_MUL;
                        busy_d  = 1'b1;
                        cnt_d   = MUL_LOAD;
                     end
                  end
`ifdef HILO_DIV_EN
                  OP_DIV, OP_DIVU: begin
                     opa_d   = a_mag;
                     opb_d   = b_mag;
                     quo_d   = a_mag;
                     rem_d   = '0;
                     qneg_d  = a_sgn ^ b_sgn;
                     rneg_d  = a_sgn;
                     dz_d    = (B == '0);
                     state_d = ST_DIV;
                     busy_d  = 1'b1;
                     cnt_d   = DIV_LOAD;
                  end
`endif
                  default: begin illegal_d = 1'b1; done_d = 1'b1; end
               endcase
            end
         end
         ST_MUL: begin
            if (cnt_q == CNT_ONE) begin
               hi_d    = mul_res[2*WIDTH-1:WIDTH];
               lo_d    = mul_res[WIDTH-1:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
`ifdef HILO_DIV_EN
         ST_DIV: begin
            quo_d = step_quo;
            rem_d = step_rem;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               hi_d      = fin_rem;
               lo_d      = fin_quo;
               done_d    = 1'b1;
               divzero_d = dz_q;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      // A flush drops any start or commit decided on this edge
      if (Cancel) begin
         state_d   = ST_IDLE;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         illegal_d = 1'b0;
         result_d  = result_q;
         hi_d      = hi_q;
         lo_d      = lo_q;
`ifdef HILO_DIV_EN
         divzero_d = 1'b0;
`endif
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
`ifdef HILO_DIV_EN
         quo_q     <= '0;
         rem_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         dz_q      <= 1'b0;
         divzero_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         result_q  <= result_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
`ifdef HILO_DIV_EN
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         dz_q      <= dz_d;
         divzero_q <= divzero_d;
`endif
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Result    = result_q;
   assign Hi        = hi_q;
   assign Lo        = lo_q;
   assign IllegalOp = illegal_q;
`ifdef HILO_DIV_EN
   assign DivZero   = divzero_q;
`else
   assign DivZero   = 1'b0;
`endif

endmodule
`default_nettype wire
